pipeline_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage RV32 pipeline. It drives the enable and flush inputs of the PC register and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves three hazard classes:
- data-memory wait (handshake with the data memory),
- taken-branch redirect,
- load-use data hazard.

It also tracks memory timeouts and keeps stall/flush performance counters.

---
 rtl/pipeline_ctrl_pkg.sv | 14 +
 rtl/pipeline_ctrl_hazard_detect.sv | 26 ++
 rtl/pipeline_ctrl.sv | 133 +++++++++++++
 tb/tb_pipeline_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer.
//   ctrl_state_t : sequencer state encoding (RUN=0, MEM_WAIT=1, FAULT=2)
//   REG_X0       : index of the hard-wired zero register
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_FAULT    = 2'd2
  } ctrl_state_t;

  localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard comparator (purely combinational).
//   id_rs1/id_rs2, id_uses_rs1/id_uses_rs2 : source operands of the ID instruction
//   ex_rd, ex_RW, ex_MR                    : destination / write / load flags of EX
//   load_use                               : ID needs a value a load in EX has not produced yet
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_RW,
  input  logic       ex_MR,
  output logic       load_use
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit  = id_uses_rs1 & (id_rs1 == ex_rd);
  assign rs2_hit  = id_uses_rs2 & (id_rs2 == ex_rd);
  // Writes to x0 are discarded, so they never create a dependency.
  assign load_use = ex_MR & ex_RW & (ex_rd != REG_X0) & (rs1_hit | rs2_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32 pipeline.
// Resolves data-memory wait, taken-branch redirect and load-use hazards,
// detects data-memory timeouts and keeps saturating stall/flush counters.
//   clk, rst                       : clock, synchronous active-high reset
//   id_*, ex_*                     : hazard inputs from the ID and EX stages
//   mem_MR, mem_MW, dmem_ready     : data-memory access in MEM and its handshake
//   *_en, *_flush                  : pipeline register controls (flush dominates enable)
//   ctrl_state                     : current sequencer state
//   mem_fault                      : sticky data-memory timeout indication
//   stall_cnt, flush_cnt           : saturating performance counters
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_RW,
  input  logic             ex_MR,
  input  logic             ex_branch_taken,
  input  logic             mem_MR,
  input  logic             mem_MW,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             mem_wb_flush,
  output logic [1:0]       ctrl_state,
  output logic             mem_fault,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  ctrl_state_t state;
  logic [7:0]  wait_cnt;
  logic        load_use;
  logic        mem_stall;
  logic        branch_flush;

  hazard_detect u_hazard_detect (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .ex_rd       (ex_rd),
    .ex_RW       (ex_RW),
    .ex_MR       (ex_MR),
    .load_use    (load_use)
  );

  assign mem_stall  = (mem_MR | mem_MW) & ~dmem_ready;
  assign ctrl_state = state;
  assign mem_fault  = (state == ST_FAULT) & ~rst;

  // Priority: reset, fault freeze, memory wait, branch redirect, load-use bubble.
  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    mem_wb_flush = 1'b0;
    branch_flush = 1'b0;
    if (rst) begin
      {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '0;
      {if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush} = '1;
    end else if (state == ST_FAULT) begin
      {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '0;
    end else if (mem_stall) begin
      // EX is frozen, so a pending branch or load-use re-evaluates on release.
      {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '0;
      mem_wb_flush = 1'b1;
    end else if (ex_branch_taken) begin
      // The ID instruction is squashed, which also resolves any load-use on it.
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      branch_flush = 1'b1;
    end else if (load_use) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_RUN;
      wait_cnt  <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      unique case (state)
        ST_RUN: begin
          if (mem_stall) begin
            state    <= ST_MEM_WAIT;
            wait_cnt <= 8'd1;
          end
        end
        ST_MEM_WAIT: begin
          if (dmem_ready) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
          end else if (mem_stall && wait_cnt == 8'(MEM_TIMEOUT)) begin
            state <= ST_FAULT;
          end else if (wait_cnt != '1) begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        ST_FAULT: state <= ST_FAULT;
        default:  state <= ST_RUN;
      endcase
      if (state != ST_FAULT && !pc_en && stall_cnt != '1)
        stall_cnt <= stall_cnt + 1'b1;
      if (branch_flush && flush_cnt != '1)
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

  localparam logic [8:0] NORM  = 9'b11111_0000;
  localparam logic [8:0] BR    = 9'b11111_1100;
  localparam logic [8:0] LU    = 9'b00111_0100;
  localparam logic [8:0] MS    = 9'b00000_0001;
  localparam logic [8:0] FRZ   = 9'b00000_0000;
  localparam logic [8:0] RSTV  = 9'b00000_1111;
  localparam logic [8:0] ALL   = 9'b11111_1111;
  localparam logic [8:0] LUM   = 9'b11011_1111;  // id_ex_en is don't-care under flush

  logic clk = 1'b0;
  logic rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic id_uses_rs1, id_uses_rs2, ex_RW, ex_MR, ex_branch_taken;
  logic mem_MR, mem_MW, dmem_ready;
  logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
  logic [1:0] ctrl_state;
  logic mem_fault;
  logic [15:0] stall_cnt, flush_cnt;
  logic [8:0] ctl;

  logic pc_en2, if_id_en2, id_ex_en2, ex_mem_en2, mem_wb_en2;
  logic if_id_flush2, id_ex_flush2, ex_mem_flush2, mem_wb_flush2;
  logic [1:0] ctrl_state2;
  logic mem_fault2;
  logic [1:0] stall_cnt2, flush_cnt2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign ctl = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush};

  pipeline_ctrl #(.MEM_TIMEOUT(15), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_RW(ex_RW), .ex_MR(ex_MR), .ex_branch_taken(ex_branch_taken),
    .mem_MR(mem_MR), .mem_MW(mem_MW), .dmem_ready(dmem_ready),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
    .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush), .ctrl_state(ctrl_state),
    .mem_fault(mem_fault), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // Narrow counters and short timeout to reach saturation quickly.
  pipeline_ctrl #(.MEM_TIMEOUT(3), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_RW(ex_RW), .ex_MR(ex_MR), .ex_branch_taken(ex_branch_taken),
    .mem_MR(mem_MR), .mem_MW(mem_MW), .dmem_ready(dmem_ready),
    .pc_en(pc_en2), .if_id_en(if_id_en2), .id_ex_en(id_ex_en2), .ex_mem_en(ex_mem_en2),
    .mem_wb_en(mem_wb_en2), .if_id_flush(if_id_flush2), .id_ex_flush(id_ex_flush2),
    .ex_mem_flush(ex_mem_flush2), .mem_wb_flush(mem_wb_flush2), .ctrl_state(ctrl_state2),
    .mem_fault(mem_fault2), .stall_cnt(stall_cnt2), .flush_cnt(flush_cnt2)
  );

  typedef struct {
    logic [4:0] rs1, rs2, rd;
    logic u1, u2, rw, mr, br, mmr, mmw, rdy;
    logic [8:0] ctl, mask;
    logic [1:0] st;
    int stall, flush;
  } vec_t;

  vec_t vecs[22];

  function automatic vec_t mk(logic [4:0] rs1, logic u1, logic [4:0] rs2, logic u2,
                              logic [4:0] rd, logic rw, logic mr, logic br,
                              logic mmr, logic mmw, logic rdy,
                              logic [8:0] c, logic [8:0] m, logic [1:0] st, int s, int f);
    vec_t v;
    v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2; v.rd = rd; v.rw = rw; v.mr = mr;
    v.br = br; v.mmr = mmr; v.mmw = mmw; v.rdy = rdy;
    v.ctl = c; v.mask = m; v.st = st; v.stall = s; v.flush = f;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    id_rs1 = v.rs1; id_uses_rs1 = v.u1; id_rs2 = v.rs2; id_uses_rs2 = v.u2;
    ex_rd = v.rd; ex_RW = v.rw; ex_MR = v.mr; ex_branch_taken = v.br;
    mem_MR = v.mmr; mem_MW = v.mmw; dmem_ready = v.rdy;
  endtask

  task automatic idle();
    drive(mk(0,0,0,0,0,0,0,0,0,0,0, NORM,ALL,0,0,0));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    vecs[0]  = mk(0,0,0,0,0,0,0, 0,0,0,0, NORM, ALL, 0, 0, 0);
    vecs[1]  = mk(3,1,0,0,3,1,0, 0,0,0,0, NORM, ALL, 0, 0, 0);
    vecs[2]  = mk(0,0,5,1,5,1,1, 0,0,0,0, LU,   LUM, 0, 0, 0);
    vecs[3]  = mk(0,0,0,0,0,0,0, 0,0,0,0, NORM, ALL, 0, 1, 0);
    vecs[4]  = mk(0,0,0,1,0,1,1, 0,0,0,0, NORM, ALL, 0, 1, 0);
    vecs[5]  = mk(7,0,0,0,7,1,1, 0,0,0,0, NORM, ALL, 0, 1, 0);
    vecs[6]  = mk(7,1,0,0,7,0,1, 0,0,0,0, NORM, ALL, 0, 1, 0);
    vecs[7]  = mk(9,1,0,0,9,1,1, 1,0,0,0, BR,   ALL, 0, 1, 0);
    vecs[8]  = mk(0,0,0,0,0,0,0, 0,0,0,0, NORM, ALL, 0, 1, 1);
    vecs[9]  = mk(0,0,0,0,0,0,0, 1,1,0,0, MS,   ALL, 0, 1, 1);
    vecs[10] = mk(0,0,0,0,0,0,0, 1,1,0,0, MS,   ALL, 1, 2, 1);
    vecs[11] = mk(0,0,0,0,0,0,0, 1,1,0,0, MS,   ALL, 1, 3, 1);
    vecs[12] = mk(0,0,0,0,0,0,0, 1,1,0,1, BR,   ALL, 1, 4, 1);
    vecs[13] = mk(0,0,0,0,0,0,0, 0,0,0,0, NORM, ALL, 0, 4, 2);
    vecs[14] = mk(0,0,0,0,0,0,0, 0,0,1,0, MS,   ALL, 0, 4, 2);
    vecs[15] = mk(0,0,0,0,0,0,0, 0,0,1,1, NORM, ALL, 1, 5, 2);
    vecs[16] = mk(0,0,0,0,0,0,0, 0,0,1,1, NORM, ALL, 0, 5, 2);
    vecs[17] = mk(0,0,5,1,5,1,1, 0,1,0,0, MS,   ALL, 0, 5, 2);
    vecs[18] = mk(0,0,5,1,5,1,1, 0,1,0,1, LU,   LUM, 1, 6, 2);
    vecs[19] = mk(0,0,0,0,0,0,0, 0,0,0,0, NORM, ALL, 0, 7, 2);
    vecs[20] = mk(0,0,0,0,0,0,0, 1,0,0,0, BR,   ALL, 0, 7, 2);
    vecs[21] = mk(0,0,0,0,0,0,0, 1,0,0,0, BR,   ALL, 0, 7, 3);

    rst = 1'b1;
    idle();
    step();
    chk("rst_ctl", 32'(ctl), 32'(RSTV));
    chk("rst_fault", 32'(mem_fault), 32'd0);
    step();
    rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i]);
      #1;
      chk($sformatf("v%0d_ctl", i), 32'(ctl & vecs[i].mask), 32'(vecs[i].ctl & vecs[i].mask));
      chk($sformatf("v%0d_state", i), 32'(ctrl_state), 32'(vecs[i].st));
      chk($sformatf("v%0d_stall", i), 32'(stall_cnt), 32'(vecs[i].stall));
      chk($sformatf("v%0d_flush", i), 32'(flush_cnt), 32'(vecs[i].flush));
      step();
    end
    chk("end_stall", 32'(stall_cnt), 32'd7);
    chk("end_flush", 32'(flush_cnt), 32'd4);
    chk("sat_stall2", 32'(stall_cnt2), 32'd3);
    chk("sat_flush2", 32'(flush_cnt2), 32'd3);

    // Store that never completes: 16 stall cycles, then FAULT.
    for (int k = 1; k <= 16; k++) begin
      drive(mk(0,0,0,0,0,0,0, 0,0,1,0, MS,ALL,0,0,0));
      #1;
      if (k == 16) begin
        chk("to16_state", 32'(ctrl_state), 32'd1);
        chk("to16_fault", 32'(mem_fault), 32'd0);
        chk("to16_ctl", 32'(ctl), 32'(MS));
      end
      step();
    end
    chk("flt_state", 32'(ctrl_state), 32'd2);
    chk("flt_fault", 32'(mem_fault), 32'd1);
    chk("flt_ctl", 32'(ctl), 32'(FRZ));
    chk("flt_stall", 32'(stall_cnt), 32'd23);
    chk("flt_state2", 32'(ctrl_state2), 32'd2);
    for (int k = 0; k < 3; k++) begin
      drive(mk(0,0,5,1,5,1,1, 1,0,0,0, FRZ,ALL,0,0,0));
      step();
    end
    chk("flt_hold_ctl", 32'(ctl), 32'(FRZ));
    chk("flt_hold_stall", 32'(stall_cnt), 32'd23);
    chk("flt_hold_flush", 32'(flush_cnt), 32'd4);
    chk("flt_hold_fault", 32'(mem_fault), 32'd1);

    rst = 1'b1;
    idle();
    #1;
    chk("frst_ctl", 32'(ctl), 32'(RSTV));
    chk("frst_fault", 32'(mem_fault), 32'd0);
    step();
    rst = 1'b0;
    #1;
    chk("frst_state", 32'(ctrl_state), 32'd0);
    chk("frst_stall", 32'(stall_cnt), 32'd0);
    chk("frst_flush", 32'(flush_cnt), 32'd0);
    chk("frst_ctl_run", 32'(ctl), 32'(NORM));

    // Reset arriving mid-wait.
    drive(mk(0,0,0,0,0,0,0, 0,1,0,0, MS,ALL,0,0,0));
    step();
    step();
    chk("mw_state", 32'(ctrl_state), 32'd1);
    rst = 1'b1;
    #1;
    chk("mwrst_ctl", 32'(ctl), 32'(RSTV));
    step();
    rst = 1'b0;
    idle();
    #1;
    chk("mwrst_state", 32'(ctrl_state), 32'd0);
    chk("mwrst_stall", 32'(stall_cnt), 32'd0);
    chk("mwrst_fault", 32'(mem_fault), 32'd0);

    // Full timeout again from clean state, bounded.
    n = 0;
    drive(mk(0,0,0,0,0,0,0, 0,1,0,0, MS,ALL,0,0,0));
    while (ctrl_state != 2'd2 && n < 40) begin
      step();
      n++;
    end
    chk("retimeout_cycles", 32'(n), 32'd16);
    chk("retimeout_stall", 32'(stall_cnt), 32'd16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
